x_top_mem_arb: RTL and testbench

Two-port arbiter that shares the single UART memory bridge between two requesters, e.g. instruction fetch (port 0) and load/store (port 1).
- Each port presents the same valid/accept memory handshake as the bridge.
- The arbiter grants one port at a time, captures that port's request into registers and drives the bridge until accept.
- It returns the bridge read data and accept pulse to the granted port only.
- A watchdog flags transactions that stall longer than p_timeout cycles.

---
 rtl/x_top_mem_arb.sv | 176 +++++++++++++++++
 tb/tb_x_top_mem_arb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_top_mem_arb.sv
// Two-port arbiter sharing one memory bridge between two requesters.
// One port owns the bridge at a time. Its request is captured into registers
// and held on the bridge until the bridge accepts it. A watchdog raises a
// sticky flag when a granted transaction stalls too long.
module x_top_mem_arb #(
    parameter bit p_rr      = 1'b1,
    parameter int p_timeout = 100000
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_p0_valid,
    input  logic        i_p0_rnw,
    input  logic [31:0] i_p0_addr,
    input  logic [31:0] i_p0_data,
    output logic        o_p0_accept,
    output logic [31:0] o_p0_data,
    input  logic        i_p1_valid,
    input  logic        i_p1_rnw,
    input  logic [31:0] i_p1_addr,
    input  logic [31:0] i_p1_data,
    output logic        o_p1_accept,
    output logic [31:0] o_p1_data,
    output logic        o_m_valid,
    output logic        o_m_rnw,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_data,
    input  logic        i_m_accept,
    input  logic [31:0] i_m_data,
    input  logic        i_clr,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam int c_cw = $clog2(p_timeout) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            last_q;
    logic            last_d;
    logic            cap_en;
    logic            cap_sel;
    logic            m_rnw_q;
    logic [31:0]     m_addr_q;
    logic [31:0]     m_data_q;
    logic [c_cw-1:0] wd_cnt_q;
    logic            timeout_q;
    logic            granted;
    logic            wd_hit;

    assign granted = (state_q != IDLE);

    // The watchdog fires on the granted cycle that completes p_timeout stalled cycles.
    assign wd_hit = granted && !i_m_accept &&
                    (wd_cnt_q == c_cw'(p_timeout - 1));

    // Next-state logic: arbitration from IDLE, and handover or release on accept.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        last_d  = last_q;
        cap_en  = 1'b0;
        cap_sel = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_p0_valid && i_p1_valid) begin
                    cap_en  = 1'b1;
                    // Round-robin gives the port that was not served last;
                    // fixed priority always gives port 0.
                    cap_sel = p_rr && !last_q;
                end else if (i_p0_valid) begin
                    cap_en  = 1'b1;
                    cap_sel = 1'b0;
                end else if (i_p1_valid) begin
                    cap_en  = 1'b1;
                    cap_sel = 1'b1;
                end
                if (cap_en) begin
                    state_d = cap_sel ? G1 : G0;
                end
            end
            G0: begin
                if (i_m_accept) begin
                    last_d = 1'b0;
                    // Port 0's own valid is stale here, so only port 1 can follow directly.
                    if (i_p1_valid) begin
                        cap_en  = 1'b1;
                        cap_sel = 1'b1;
                        state_d = G1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            G1: begin
                if (i_m_accept) begin
                    last_d = 1'b1;
                    if (i_p0_valid) begin
                        cap_en  = 1'b1;
                        cap_sel = 1'b0;
                        state_d = G0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and last-served port.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!i_nrst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Capture the winning request when a grant starts; held for the whole grant.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        // NOTE: these are plain registers, not a memory array, so they take the
        // async reset and drive known zeros onto the bridge after reset.
        if (!i_nrst) begin
            m_rnw_q  <= 1'b0;
            m_addr_q <= '0;
            m_data_q <= '0;
        end else if (cap_en) begin
            m_rnw_q  <= cap_sel ? i_p1_rnw  : i_p0_rnw;
            m_addr_q <= cap_sel ? i_p1_addr : i_p0_addr;
            m_data_q <= cap_sel ? i_p1_data : i_p0_data;
        end
    end

    // Watchdog: count granted cycles from grant entry, saturate, set sticky flag.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (cap_en) begin
                wd_cnt_q <= '0;
            end else if (granted && (wd_cnt_q != '1)) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (wd_hit) begin
                timeout_q <= 1'b1;
            end else if (i_clr) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign o_m_valid   = granted;
    assign o_m_rnw     = m_rnw_q;
    assign o_m_addr    = m_addr_q;
    assign o_m_data    = m_data_q;
    assign o_grant     = {state_q == G1, state_q == G0};
    assign o_timeout   = timeout_q;

    assign o_p0_accept = (state_q == G0) && i_m_accept;
    assign o_p1_accept = (state_q == G1) && i_m_accept;
    assign o_p0_data   = o_p0_accept ? i_m_data : 32'h0;
    assign o_p1_data   = o_p1_accept ? i_m_data : 32'h0;

endmodule

// File: tb/tb_x_top_mem_arb.sv
// Testbench for x_top_mem_arb.
// Two instances share one stimulus stream: A is round-robin with timeout 8,
// B is fixed priority with timeout 12. A transaction-level model per instance
// predicts every output each cycle.
module tb_x_top_mem_arb;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_p0_valid, i_p0_rnw;
    logic [31:0] i_p0_addr, i_p0_data;
    logic        i_p1_valid, i_p1_rnw;
    logic [31:0] i_p1_addr, i_p1_data;
    logic        i_m_accept;
    logic [31:0] i_m_data;
    logic        i_clr;

    logic [1:0]  p0_accept, p1_accept, m_valid, m_rnw, timeout;
    logic [31:0] p0_data [2];
    logic [31:0] p1_data [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [1:0]  grant   [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    x_top_mem_arb #(.p_rr(1'b1), .p_timeout(8)) dut_a (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_p0_valid(i_p0_valid), .i_p0_rnw(i_p0_rnw), .i_p0_addr(i_p0_addr), .i_p0_data(i_p0_data),
        .o_p0_accept(p0_accept[0]), .o_p0_data(p0_data[0]),
        .i_p1_valid(i_p1_valid), .i_p1_rnw(i_p1_rnw), .i_p1_addr(i_p1_addr), .i_p1_data(i_p1_data),
        .o_p1_accept(p1_accept[0]), .o_p1_data(p1_data[0]),
        .o_m_valid(m_valid[0]), .o_m_rnw(m_rnw[0]), .o_m_addr(m_addr[0]), .o_m_data(m_wdata[0]),
        .i_m_accept(i_m_accept), .i_m_data(i_m_data), .i_clr(i_clr),
        .o_grant(grant[0]), .o_timeout(timeout[0])
    );

    x_top_mem_arb #(.p_rr(1'b0), .p_timeout(12)) dut_b (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_p0_valid(i_p0_valid), .i_p0_rnw(i_p0_rnw), .i_p0_addr(i_p0_addr), .i_p0_data(i_p0_data),
        .o_p0_accept(p0_accept[1]), .o_p0_data(p0_data[1]),
        .i_p1_valid(i_p1_valid), .i_p1_rnw(i_p1_rnw), .i_p1_addr(i_p1_addr), .i_p1_data(i_p1_data),
        .o_p1_accept(p1_accept[1]), .o_p1_data(p1_data[1]),
        .o_m_valid(m_valid[1]), .o_m_rnw(m_rnw[1]), .o_m_addr(m_addr[1]), .o_m_data(m_wdata[1]),
        .i_m_accept(i_m_accept), .i_m_data(i_m_data), .i_clr(i_clr),
        .o_grant(grant[1]), .o_timeout(timeout[1])
    );

    // Model configuration and state, one entry per instance.
    int          c_rr [2] = '{1, 0};
    int          c_to [2] = '{8, 12};
    int          md_owner   [2];  // -1 = nobody, else the granted port
    int          md_last    [2];
    int          md_elapsed [2];  // granted cycles of the current transaction
    bit          md_tmo     [2];
    bit          md_rnw     [2];
    logic [31:0] md_addr    [2];
    logic [31:0] md_data    [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            md_owner[k]   = -1;
            md_last[k]    = 1;
            md_elapsed[k] = 0;
            md_tmo[k]     = 1'b0;
            md_rnw[k]     = 1'b0;
            md_addr[k]    = 32'h0;
            md_data[k]    = 32'h0;
        end
    endfunction

    function automatic void model_grant(input int k, input int p);
        md_owner[k]   = p;
        md_elapsed[k] = 0;
        md_rnw[k]     = (p == 0) ? i_p0_rnw  : i_p1_rnw;
        md_addr[k]    = (p == 0) ? i_p0_addr : i_p1_addr;
        md_data[k]    = (p == 0) ? i_p0_data : i_p1_data;
    endfunction

    // Advance one instance's model by one clock using the current inputs.
    function automatic void model_step(input int k);
        bit valid [2];
        bit hit;
        int other;
        valid[0] = i_p0_valid;
        valid[1] = i_p1_valid;
        hit      = 1'b0;
        if (md_owner[k] >= 0) begin
            md_elapsed[k]++;
            if (!i_m_accept && md_elapsed[k] == c_to[k]) hit = 1'b1;
        end
        md_tmo[k] = hit ? 1'b1 : (i_clr ? 1'b0 : md_tmo[k]);
        if (md_owner[k] < 0) begin
            if (valid[0] && valid[1]) begin
                model_grant(k, (c_rr[k] != 0 && md_last[k] == 0) ? 1 : 0);
            end else if (valid[0]) begin
                model_grant(k, 0);
            end else if (valid[1]) begin
                model_grant(k, 1);
            end
        end else if (i_m_accept) begin
            other      = 1 - md_owner[k];
            md_last[k] = md_owner[k];
            if (valid[other]) model_grant(k, other);
            else md_owner[k] = -1;
        end
    endfunction

    task automatic compare_dut(input int k);
        string       p;
        logic [1:0]  exp_grant;
        logic [31:0] exp_d0, exp_d1;
        p         = (k == 0) ? "A" : "B";
        exp_grant = (md_owner[k] == 0) ? 2'b01 : (md_owner[k] == 1) ? 2'b10 : 2'b00;
        exp_d0    = (md_owner[k] == 0 && i_m_accept) ? i_m_data : 32'h0;
        exp_d1    = (md_owner[k] == 1 && i_m_accept) ? i_m_data : 32'h0;
        check({p, " m_valid"}, m_valid[k], md_owner[k] >= 0);
        if (md_owner[k] >= 0) begin
            check({p, " m_rnw"},  m_rnw[k],   md_rnw[k]);
            check({p, " m_addr"}, m_addr[k],  md_addr[k]);
            check({p, " m_data"}, m_wdata[k], md_data[k]);
        end
        check({p, " grant"},     grant[k],     exp_grant);
        check({p, " p0_accept"}, p0_accept[k], md_owner[k] == 0 && i_m_accept);
        check({p, " p0_data"},   p0_data[k],   exp_d0);
        check({p, " p1_accept"}, p1_accept[k], md_owner[k] == 1 && i_m_accept);
        check({p, " p1_data"},   p1_data[k],   exp_d1);
        check({p, " timeout"},   timeout[k],   md_tmo[k]);
    endtask

    // Compare at the falling edge, advance the model, then return just after the rising edge.
    task automatic tick();
        @(negedge i_clk);
        compare_dut(0);
        compare_dut(1);
        model_step(0);
        model_step(1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_p0_valid = 1'b0; i_p0_rnw = 1'b0; i_p0_addr = 32'h0; i_p0_data = 32'h0;
        i_p1_valid = 1'b0; i_p1_rnw = 1'b0; i_p1_addr = 32'h0; i_p1_data = 32'h0;
        i_m_accept = 1'b0; i_m_data = 32'h0; i_clr = 1'b0;
    endtask

    task automatic do_reset();
        i_nrst = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_nrst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acc_pct;

        // Reset state.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            check("reset m_valid", m_valid[k], 1'b0);
            check("reset grant",   grant[k],   2'b00);
            check("reset timeout", timeout[k], 1'b0);
            check("reset m_addr",  m_addr[k],  32'h0);
        end

        // Single port-0 read: one-cycle grant latency, same-cycle accept.
        i_p0_valid = 1'b1; i_p0_rnw = 1'b1; i_p0_addr = 32'h0000_0010;
        #1 check("t1 no grant yet", grant[0], 2'b00);
        tick();
        check("t1 m_valid", m_valid[0], 1'b1);
        check("t1 m_addr",  m_addr[0],  32'h0000_0010);
        check("t1 m_rnw",   m_rnw[0],   1'b1);
        check("t1 grant",   grant[0],   2'b01);
        tick();
        i_m_accept = 1'b1; i_m_data = 32'hDEAD_BEEF;
        #1;
        check("t1 p0_accept", p0_accept[0], 1'b1);
        check("t1 p0_data",   p0_data[0],   32'hDEAD_BEEF);
        check("t1 p1_accept", p1_accept[0], 1'b0);
        tick();
        idle_inputs();
        tick();

        // Contention with round-robin: port 0 first, zero-bubble handover to port 1.
        do_reset();
        i_p0_valid = 1'b1; i_p0_addr = 32'h100;
        i_p1_valid = 1'b1; i_p1_addr = 32'h200;
        tick();
        check("t2 first grant", grant[0], 2'b01);
        i_m_accept = 1'b1;
        tick();
        i_m_accept = 1'b0;
        #1 check("t2 handover grant", grant[0], 2'b10);
        tick();
        i_m_accept = 1'b1;
        tick();
        i_m_accept = 1'b0;
        #1 check("t2 handover back", grant[0], 2'b01);
        tick();
        idle_inputs();
        i_m_accept = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Both ports held valid continuously: alternation p0, p1, p0, p1.
        do_reset();
        i_p0_valid = 1'b1; i_p1_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            i_m_accept = 1'b1; i_m_data = $urandom;
            #1 check("t3 grant order B", grant[1], (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            i_m_accept = 1'b0;
            tick();
        end
        idle_inputs();
        i_m_accept = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Port-1 write: captured data holds while the requester changes its bus.
        do_reset();
        i_p1_valid = 1'b1; i_p1_rnw = 1'b0; i_p1_addr = 32'h4; i_p1_data = 32'h1234_5678;
        tick();
        i_p1_data = 32'hFFFF_0000;
        repeat (3) tick();
        check("t4 m_data held", m_wdata[0], 32'h1234_5678);
        check("t4 m_addr held", m_addr[0],  32'h4);
        i_m_accept = 1'b1;
        tick();
        idle_inputs();
        tick();

        // Watchdog on A (timeout 8): set after 8 stalled cycles, sticky, clearable.
        do_reset();
        i_p0_valid = 1'b1; i_p0_addr = 32'h80;
        tick();
        repeat (7) tick();
        check("t5 not yet", timeout[0], 1'b0);
        tick();
        check("t5 set", timeout[0], 1'b1);
        repeat (2) tick();
        i_m_accept = 1'b1; i_p0_valid = 1'b0;
        tick();
        i_m_accept = 1'b0;
        #1 check("t5 sticky after accept", timeout[0], 1'b1);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        #1 check("t5 cleared", timeout[0], 1'b0);
        i_p0_valid = 1'b1;
        tick();
        repeat (7) tick();
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        #1 check("t5 set wins over clr", timeout[0], 1'b1);
        i_m_accept = 1'b1; i_p0_valid = 1'b0;
        tick();
        idle_inputs();
        tick();

        // Asynchronous reset while port 1 owns the bridge.
        do_reset();
        i_p1_valid = 1'b1; i_p1_addr = 32'h44;
        tick();
        i_m_accept = 1'b1;
        #1;
        i_nrst = 1'b0;
        model_reset();
        #1;
        check("t6 m_valid in reset",   m_valid[0],   1'b0);
        check("t6 grant in reset",     grant[0],     2'b00);
        check("t6 p1_accept in reset", p1_accept[0], 1'b0);
        idle_inputs();
        i_p0_valid = 1'b1; i_p1_valid = 1'b1;
        i_nrst = 1'b1;
        tick();
        check("t6 first after reset A", grant[0], 2'b01);
        check("t6 first after reset B", grant[1], 2'b01);
        i_m_accept = 1'b1;
        tick();

        // Randomized traffic, with stall-heavy phases to exercise the watchdog.
        do_reset();
        acc_pct = 40;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) acc_pct = ($urandom_range(0, 1) != 0) ? 40 : 2;
            if (i == 2000) do_reset();
            i_p0_valid = ($urandom_range(0, 99) < 60);
            i_p0_rnw   = $urandom_range(0, 1);
            i_p0_addr  = $urandom;
            i_p0_data  = $urandom;
            i_p1_valid = ($urandom_range(0, 99) < 60);
            i_p1_rnw   = $urandom_range(0, 1);
            i_p1_addr  = $urandom;
            i_p1_data  = $urandom;
            i_m_accept = ($urandom_range(0, 99) < acc_pct);
            i_m_data   = $urandom;
            i_clr      = ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
